// File: rtl/fft_cbfp_pkg.sv
// Shared constants, sample-block type and read-engine state for the CBFP / FFT datapath.
// Types only; no logic, no latency, no flow control.
package fft_cbfp_pkg;

   localparam int DATA_WIDTH  = 12;
   localparam int SHIFT_WIDTH = 5;
   localparam int BLOCK_SIZE  = 8;

   typedef struct packed {
      logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r;
      logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] q;
   } cplx_blk_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RUN  = 1'b1
   } rd_state_t;

endpackage

// File: rtl/cbfp1_rbuf_bank.sv
// One frame bank: F entries of {add block, sub block, two exponents}, one write port, two async read ports.
// Write lands on the clock edge, reads are combinational; there is no flow control.
module cbfp1_rbuf_bank
   import fft_cbfp_pkg::*;
#(
   parameter int FRAME_CYCLES = 4,
   parameter int IW           = $clog2(FRAME_CYCLES)
) (
   input  logic                   clk,
   input  logic                   i_wr_en,
   input  logic [IW-1:0]          i_wr_idx,
   input  cplx_blk_t              i_wr_add,
   input  cplx_blk_t              i_wr_sub,
   input  logic [SHIFT_WIDTH-1:0] i_wr_exp_add,
   input  logic [SHIFT_WIDTH-1:0] i_wr_exp_sub,
   input  logic [IW-1:0]          i_rd0_idx,
   output cplx_blk_t              o_rd0_add,
   output cplx_blk_t              o_rd0_sub,
   output logic [SHIFT_WIDTH-1:0] o_rd0_exp_add,
   output logic [SHIFT_WIDTH-1:0] o_rd0_exp_sub,
   input  logic [IW-1:0]          i_rd1_idx,
   output cplx_blk_t              o_rd1_add,
   output cplx_blk_t              o_rd1_sub,
   output logic [SHIFT_WIDTH-1:0] o_rd1_exp_add,
   output logic [SHIFT_WIDTH-1:0] o_rd1_exp_sub
);

   cplx_blk_t              r_add     [FRAME_CYCLES];
   cplx_blk_t              r_sub     [FRAME_CYCLES];
   logic [SHIFT_WIDTH-1:0] r_exp_add [FRAME_CYCLES];
   logic [SHIFT_WIDTH-1:0] r_exp_sub [FRAME_CYCLES];

   // Contents are don't-care after reset, so the store carries no reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_add[i_wr_idx]     <= i_wr_add;
         r_sub[i_wr_idx]     <= i_wr_sub;
         r_exp_add[i_wr_idx] <= i_wr_exp_add;
         r_exp_sub[i_wr_idx] <= i_wr_exp_sub;
      end
   end

   assign o_rd0_add     = r_add[i_rd0_idx];
   assign o_rd0_sub     = r_sub[i_rd0_idx];
   assign o_rd0_exp_add = r_exp_add[i_rd0_idx];
   assign o_rd0_exp_sub = r_exp_sub[i_rd0_idx];
   assign o_rd1_add     = r_add[i_rd1_idx];
   assign o_rd1_sub     = r_sub[i_rd1_idx];
   assign o_rd1_exp_add = r_exp_add[i_rd1_idx];
   assign o_rd1_exp_sub = r_exp_sub[i_rd1_idx];

endmodule

// File: rtl/cbfp1_reorder_buf.sv
// Ping-pong frame buffer replaying F add/sub beats as stride-halved top/bot pairs with their exponents.
// Beat 0 leaves one edge after the last input beat; no backpressure, valid_mod2 runs F cycles per frame.
module cbfp1_reorder_buf #(
   parameter int BLOCK_SIZE   = 8,
   parameter int DATA_WIDTH   = 12,
   parameter int SHIFT_WIDTH  = 5,
   parameter int FRAME_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          valid_mod1,
   input  logic signed [DATA_WIDTH-1:0]  din_R_add [BLOCK_SIZE],
   input  logic signed [DATA_WIDTH-1:0]  din_Q_add [BLOCK_SIZE],
   input  logic signed [DATA_WIDTH-1:0]  din_R_sub [BLOCK_SIZE],
   input  logic signed [DATA_WIDTH-1:0]  din_Q_sub [BLOCK_SIZE],
   input  logic        [SHIFT_WIDTH-1:0] shift_add,
   input  logic        [SHIFT_WIDTH-1:0] shift_sub,
   output logic signed [DATA_WIDTH-1:0]  dout_R_top [BLOCK_SIZE],
   output logic signed [DATA_WIDTH-1:0]  dout_Q_top [BLOCK_SIZE],
   output logic signed [DATA_WIDTH-1:0]  dout_R_bot [BLOCK_SIZE],
   output logic signed [DATA_WIDTH-1:0]  dout_Q_bot [BLOCK_SIZE],
   output logic        [SHIFT_WIDTH-1:0] exp_top,
   output logic        [SHIFT_WIDTH-1:0] exp_bot,
   output logic                          valid_mod2,
   output logic                          frame_start
);

   import fft_cbfp_pkg::*;

   localparam int             IW     = $clog2(FRAME_CYCLES);
   localparam logic [IW-1:0]  LAST   = IW'(FRAME_CYCLES - 1);
   localparam logic [IW-1:0]  HALF_I = IW'(FRAME_CYCLES / 2);

   cplx_blk_t w_din_add, w_din_sub;

   always_comb begin
      w_din_add = '0;
      w_din_sub = '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         w_din_add.r[i] = din_R_add[i];
         w_din_add.q[i] = din_Q_add[i];
         w_din_sub.r[i] = din_R_sub[i];
         w_din_sub.q[i] = din_Q_sub[i];
      end
   end

   logic [IW-1:0] r_wr_cnt;
   logic          r_wr_bank;
   logic          w_launch;

   assign w_launch = valid_mod1 && (r_wr_cnt == LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_cnt  <= '0;
         r_wr_bank <= 1'b0;
      end else if (valid_mod1) begin
         if (w_launch) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_cnt  <= r_wr_cnt + 1'b1;
         end
      end
   end

   logic [IW-1:0]          w_top_idx, w_bot_idx;
   cplx_blk_t              w_rd0_add [2];
   cplx_blk_t              w_rd0_sub [2];
   cplx_blk_t              w_rd1_add [2];
   cplx_blk_t              w_rd1_sub [2];
   logic [SHIFT_WIDTH-1:0] w_rd0_exp_add [2];
   logic [SHIFT_WIDTH-1:0] w_rd0_exp_sub [2];
   logic [SHIFT_WIDTH-1:0] w_rd1_exp_add [2];
   logic [SHIFT_WIDTH-1:0] w_rd1_exp_sub [2];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      cbfp1_rbuf_bank #(
         .FRAME_CYCLES (FRAME_CYCLES),
         .IW           (IW)
      ) u_bank (
         .clk           (clk),
         .i_wr_en       (valid_mod1 && (r_wr_bank == 1'(b))),
         .i_wr_idx      (r_wr_cnt),
         .i_wr_add      (w_din_add),
         .i_wr_sub      (w_din_sub),
         .i_wr_exp_add  (shift_add),
         .i_wr_exp_sub  (shift_sub),
         .i_rd0_idx     (w_top_idx),
         .o_rd0_add     (w_rd0_add[b]),
         .o_rd0_sub     (w_rd0_sub[b]),
         .o_rd0_exp_add (w_rd0_exp_add[b]),
         .o_rd0_exp_sub (w_rd0_exp_sub[b]),
         .i_rd1_idx     (w_bot_idx),
         .o_rd1_add     (w_rd1_add[b]),
         .o_rd1_sub     (w_rd1_sub[b]),
         .o_rd1_exp_add (w_rd1_exp_add[b]),
         .o_rd1_exp_sub (w_rd1_exp_sub[b])
      );
   end

   rd_state_t     r_state, w_state_nxt;
   logic [IW-1:0] r_beat, w_beat_nxt;
   logic          r_rd_bank, w_rd_bank_nxt;
   logic          w_load;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= RD_IDLE;
         r_beat    <= '0;
         r_rd_bank <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_beat    <= w_beat_nxt;
         r_rd_bank <= w_rd_bank_nxt;
      end
   end

   // A launch on the final RUN beat chains straight into the next frame.
   always_comb begin
      w_state_nxt   = r_state;
      w_beat_nxt    = r_beat;
      w_rd_bank_nxt = r_rd_bank;
      w_load        = 1'b0;
      case (r_state)
         RD_IDLE: begin
            if (w_launch) begin
               w_state_nxt   = RD_RUN;
               w_beat_nxt    = '0;
               w_rd_bank_nxt = r_wr_bank;
            end
         end
         RD_RUN: begin
            w_load = 1'b1;
            if (r_beat == LAST) begin
               w_beat_nxt = '0;
               if (w_launch) begin
                  w_rd_bank_nxt = r_wr_bank;
               end else begin
                  w_state_nxt   = RD_IDLE;
               end
            end else begin
               w_beat_nxt = r_beat + 1'b1;
            end
         end
         default: w_state_nxt = RD_IDLE;
      endcase
   end

   logic w_second;

   assign w_second  = (r_beat >= HALF_I);
   assign w_top_idx = w_second ? (r_beat - HALF_I) : r_beat;
   assign w_bot_idx = w_second ? r_beat : (r_beat + HALF_I);

   cplx_blk_t              r_top, r_bot;
   logic [SHIFT_WIDTH-1:0] r_exp_top, r_exp_bot;
   logic                   r_vld, r_fstart;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_top     <= '0;
         r_bot     <= '0;
         r_exp_top <= '0;
         r_exp_bot <= '0;
         r_vld     <= 1'b0;
         r_fstart  <= 1'b0;
      end else begin
         r_vld    <= w_load;
         r_fstart <= w_load && (r_beat == '0);
         if (w_load) begin
            r_top     <= w_second ? w_rd0_sub[r_rd_bank]     : w_rd0_add[r_rd_bank];
            r_bot     <= w_second ? w_rd1_sub[r_rd_bank]     : w_rd1_add[r_rd_bank];
            r_exp_top <= w_second ? w_rd0_exp_sub[r_rd_bank] : w_rd0_exp_add[r_rd_bank];
            r_exp_bot <= w_second ? w_rd1_exp_sub[r_rd_bank] : w_rd1_exp_add[r_rd_bank];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         dout_R_top[i] = r_top.r[i];
         dout_Q_top[i] = r_top.q[i];
         dout_R_bot[i] = r_bot.r[i];
         dout_Q_bot[i] = r_bot.q[i];
      end
   end

   assign exp_top     = r_exp_top;
   assign exp_bot     = r_exp_bot;
   assign valid_mod2  = r_vld;
   assign frame_start = r_fstart;

   // Refilling a bank needs at least F beats, so a launch can only land on the last read beat.
   a_no_collision: assert property (@(posedge clk) disable iff (!rstn)
      !(w_launch && (r_state == RD_RUN) && (r_beat != LAST)));

endmodule

// File: tb/tb_cbfp1_reorder_buf.sv
// Scoreboard bench for cbfp1_reorder_buf (F=4): driver queues expected pairs per completed frame,
// a negedge monitor pops and checks data, exponents, frame_start and exact output cycle.
module tb_cbfp1_reorder_buf;

   localparam int F  = 4;
   localparam int BS = 8;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic valid_mod1 = 1'b0;
   logic signed [11:0] din_R_add [BS];
   logic signed [11:0] din_Q_add [BS];
   logic signed [11:0] din_R_sub [BS];
   logic signed [11:0] din_Q_sub [BS];
   logic [4:0] shift_add = '0, shift_sub = '0;
   logic signed [11:0] dout_R_top [BS];
   logic signed [11:0] dout_Q_top [BS];
   logic signed [11:0] dout_R_bot [BS];
   logic signed [11:0] dout_Q_bot [BS];
   logic [4:0] exp_top, exp_bot;
   logic valid_mod2, frame_start;

   cbfp1_reorder_buf #(.BLOCK_SIZE(8), .DATA_WIDTH(12), .SHIFT_WIDTH(5), .FRAME_CYCLES(F)) dut (
      .clk(clk), .rstn(rstn), .valid_mod1(valid_mod1),
      .din_R_add(din_R_add), .din_Q_add(din_Q_add),
      .din_R_sub(din_R_sub), .din_Q_sub(din_Q_sub),
      .shift_add(shift_add), .shift_sub(shift_sub),
      .dout_R_top(dout_R_top), .dout_Q_top(dout_Q_top),
      .dout_R_bot(dout_R_bot), .dout_Q_bot(dout_Q_bot),
      .exp_top(exp_top), .exp_bot(exp_bot),
      .valid_mod2(valid_mod2), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [383:0] dat;
      logic [9:0]   exps;
      logic         fs;
      int           due;
   } exp_t;
   exp_t sbq[$];

   // Reference frame: accepted blocks indexed by arrival order within the frame.
   logic signed [11:0] m_ar [F][BS];
   logic signed [11:0] m_aq [F][BS];
   logic signed [11:0] m_sr [F][BS];
   logic signed [11:0] m_sq [F][BS];
   logic [4:0] m_ea [F];
   logic [4:0] m_es [F];
   int m_cnt = 0;

   function automatic logic [95:0] pk(input logic signed [11:0] a [BS]);
      logic [95:0] v;
      for (int i = 0; i < BS; i++) v[i*12 +: 12] = a[i];
      return v;
   endfunction

   function automatic logic [383:0] out_dat();
      return {pk(dout_R_top), pk(dout_Q_top), pk(dout_R_bot), pk(dout_Q_bot)};
   endfunction

   task automatic check(input string name, input logic [383:0] act, input logic [383:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, req);
      end
   endtask

   // Pair order: first half pairs add_j with add_{j+F/2}, second half pairs sub_{j-F/2} with sub_j.
   task automatic push_frame(input int n);
      exp_t e;
      int t, b;
      for (int j = 0; j < F; j++) begin
         if (j < F / 2) begin
            t = j; b = j + F / 2;
            e.dat  = {pk(m_ar[t]), pk(m_aq[t]), pk(m_ar[b]), pk(m_aq[b])};
            e.exps = {m_ea[t], m_ea[b]};
         end else begin
            t = j - F / 2; b = j;
            e.dat  = {pk(m_sr[t]), pk(m_sq[t]), pk(m_sr[b]), pk(m_sq[b])};
            e.exps = {m_es[t], m_es[b]};
         end
         e.fs  = (j == 0);
         e.due = n + 2 + j;
         sbq.push_back(e);
      end
   endtask

   function automatic logic signed [11:0] gen(input int mode, input int k, input int lane, input int sel);
      if (mode == 0) begin
         case (sel)
            0: return 12'(16 * k + lane);
            1: return 12'(-(16 * k + lane) - 1);
            2: return 12'(16 * k + lane + 512);
            default: return 12'(-(16 * k + lane) - 700);
         endcase
      end else if (mode == 2) begin
         return ($urandom_range(0, 1) != 0) ? 12'sh800 : 12'sh7FF;
      end
      return 12'($urandom);
   endfunction

   // mode 0: directed 16*k+lane pattern, 1: random, 2: extremes.
   task automatic beat(input bit v, input int mode);
      int k;
      @(posedge clk); #1;
      k = m_cnt;
      valid_mod1 = v;
      for (int i = 0; i < BS; i++) begin
         din_R_add[i] = gen(mode, k, i, 0);
         din_Q_add[i] = gen(mode, k, i, 1);
         din_R_sub[i] = gen(mode, k, i, 2);
         din_Q_sub[i] = gen(mode, k, i, 3);
      end
      if (mode == 0) begin
         shift_add = 5'(k); shift_sub = 5'(k + 8);
      end else if (mode == 2) begin
         shift_add = ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0;
         shift_sub = ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0;
      end else begin
         shift_add = 5'($urandom); shift_sub = 5'($urandom);
      end
      if (v) begin
         for (int i = 0; i < BS; i++) begin
            m_ar[k][i] = din_R_add[i]; m_aq[k][i] = din_Q_add[i];
            m_sr[k][i] = din_R_sub[i]; m_sq[k][i] = din_Q_sub[i];
         end
         m_ea[k] = shift_add; m_es[k] = shift_sub;
         m_cnt++;
         if (m_cnt == F) begin
            push_frame(cyc);
            m_cnt = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 384'(valid_mod2), 384'(0));
      check({tag, "_fstart"}, 384'(frame_start), 384'(0));
      check({tag, "_data"}, out_dat(), 384'(0));
      check({tag, "_exp"}, 384'({exp_top, exp_bot}), 384'(0));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rstn = 1'b0;
      valid_mod1 = 1'b0;
      m_cnt = 0;
      sbq.delete();
      #1;
      check_zero("rst");
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (valid_mod2) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_valid at cyc %0d: got valid_mod2=1 want 0", cyc);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("out_cycle", 384'(cyc), 384'(e.due));
               check("out_data", out_dat(), e.dat);
               check("out_exp", 384'({exp_top, exp_bot}), 384'(e.exps));
               check("out_fstart", 384'(frame_start), 384'(e.fs));
            end
         end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL missing_beat at cyc %0d: got valid_mod2=0 want beat due %0d", cyc, sbq[0].due);
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < BS; i++) begin
         din_R_add[i] = '0; din_Q_add[i] = '0; din_R_sub[i] = '0; din_Q_sub[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_zero("init");
      rstn = 1'b1;
      idle(2);

      for (int k = 0; k < F; k++) beat(1'b1, 0);
      idle(6);

      for (int k = 0; k < 3 * F; k++) beat(1'b1, 1);
      idle(6);

      begin
         bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
         for (int i = 0; i < 7; i++) beat(pat[i], 0);
      end
      idle(6);

      beat(1'b1, 1); beat(1'b1, 1);
      do_reset();
      for (int k = 0; k < F; k++) beat(1'b1, 1);
      idle(6);

      for (int k = 0; k < F; k++) beat(1'b1, 1);
      idle(2);
      do_reset();
      idle(4);

      for (int k = 0; k < 2 * F; k++) beat(1'b1, 2);
      idle(6);

      for (int i = 0; i < 40; i++) beat(1'($urandom_range(0, 1)), 1);
      while (m_cnt != 0) beat(1'b1, 1);
      idle(8);

      check("queue_drained", 384'(sbq.size()), 384'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
